// File: rtl/status_flag_unit_pkg.sv
// status_flag_unit_pkg: ALU command encodings and NZCV bit positions shared by the flag unit
package status_flag_unit_pkg;
    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;
endpackage

// File: rtl/status_flag_unit_alu_core.sv
// alu_core: combinational ALU producing the result and candidate NZCV flags
module alu_core
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       cmd_i,
    input  logic             cin_i,
    input  logic             c_old_i,
    input  logic             v_old_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       nzcv_o
);
    localparam int MSB = WIDTH - 1;
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           is_add;
    logic           is_sub;
    assign is_add = (cmd_i == EXE_CMD_ADD) | (cmd_i == EXE_CMD_ADC);
    assign is_sub = (cmd_i == EXE_CMD_SUB) | (cmd_i == EXE_CMD_SBC);
    // The extra top bit is carry for adds and the borrow sign for subtracts
    assign add_w = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cmd_i == EXE_CMD_ADC && cin_i);
    assign sub_w = {1'b0, a_i} - {1'b0, b_i} - (WIDTH+1)'(cmd_i == EXE_CMD_SBC && !cin_i);
    always_comb begin
        case (cmd_i)
            EXE_CMD_MOV: result_o = b_i;
            EXE_CMD_MVN: result_o = ~b_i;
            EXE_CMD_ADD,
            EXE_CMD_ADC: result_o = add_w[WIDTH-1:0];
            EXE_CMD_SUB,
            EXE_CMD_SBC: result_o = sub_w[WIDTH-1:0];
            EXE_CMD_AND: result_o = a_i & b_i;
            EXE_CMD_ORR: result_o = a_i | b_i;
            EXE_CMD_EOR: result_o = a_i ^ b_i;
            default:     result_o = '0;
        endcase
    end
    always_comb begin
        nzcv_o    = '0;
        nzcv_o[N] = result_o[MSB];
        nzcv_o[Z] = (result_o == '0);
        nzcv_o[C] = is_add ? add_w[WIDTH] : is_sub ? ~sub_w[WIDTH] : c_old_i;
        nzcv_o[V] = is_add ? (a_i[MSB] == b_i[MSB]) & (result_o[MSB] != a_i[MSB]) :
                    is_sub ? (a_i[MSB] != b_i[MSB]) & (result_o[MSB] != a_i[MSB]) : v_old_i;
    end
endmodule

// File: rtl/status_flag_unit.sv
// status_flag_unit: EXE-stage ALU plus the NZCV status register feeding the ID condition checker
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val_rn,
    input  logic [WIDTH-1:0] val2,
    input  logic             s_bit,
    input  logic             update_en,
    input  logic             freeze,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_result,
    output logic             sr_n,
    output logic             sr_z,
    output logic             sr_c,
    output logic             sr_v,
    output logic             flag_hazard
);
    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic [3:0] nzcv;
    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a_i      (val_rn),
        .b_i      (val2),
        .cmd_i    (exe_cmd),
        .cin_i    (sr_q[C]),
        .c_old_i  (sr_q[C]),
        .v_old_i  (sr_q[V]),
        .result_o (alu_result),
        .nzcv_o   (nzcv)
    );
    // Hazard ignores freeze: a stalled flag-setter still means flags are about to change
    assign flag_hazard = s_bit & update_en & ~flush;
    assign sr_d        = (flag_hazard & ~freeze) ? nzcv : sr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end
    assign sr_n = sr_q[N];
    assign sr_z = sr_q[Z];
    assign sr_c = sr_q[C];
    assign sr_v = sr_q[V];
endmodule
